// File: rtl/puf_cr_seq_if.sv
// puf_cr_seq_if: challenge/response bus between the sequencer, UART sides and PUF (PUF_LOOPBACK_EN adds check)
interface puf_cr_seq_if #(
    parameter int CHAL_W = 16,
    parameter int RESP_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [CHAL_W-1:0] challenge;
    logic              puf_en;
    logic [RESP_W-1:0] response;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;
`ifdef PUF_LOOPBACK_EN
    logic              check;
    modport slave  (input rx_data, rx_valid, response, tx_ready, check,
                    output rx_ready, challenge, puf_en, tx_data, tx_valid, busy, done);
    modport master (output rx_data, rx_valid, response, tx_ready, check,
                    input rx_ready, challenge, puf_en, tx_data, tx_valid, busy, done);
`else
    modport slave  (input rx_data, rx_valid, response, tx_ready,
                    output rx_ready, challenge, puf_en, tx_data, tx_valid, busy, done);
    modport master (output rx_data, rx_valid, response, tx_ready,
                    input rx_ready, challenge, puf_en, tx_data, tx_valid, busy, done);
`endif
endinterface

// File: rtl/puf_cr_seq.sv
// puf_cr_seq: byte-stream challenge assembly, Gray-coded PUF evaluation, byte-serial response (PUF_LOOPBACK_EN: check selects challenge loopback)
module puf_cr_seq #(
    parameter int CHAL_W     = 16,
    parameter int RESP_W     = 32,
    parameter int SETTLE_CYC = 4,
    parameter int RX_TIMEOUT = 0
) (
    input logic         clk,
    input logic         rst,
    puf_cr_seq_if.slave bus
);
    localparam int CB  = CHAL_W / 8;
    localparam int RB  = RESP_W / 8;
    localparam int CBW = (CB > 1) ? $clog2(CB) : 1;
    localparam int RBW = (RB > 1) ? $clog2(RB) : 1;
    localparam int SW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int IW  = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

    typedef enum logic [1:0] {S_RX, S_EVAL, S_TX} state_t;

    state_t            state_q;
    logic [CBW-1:0]    rcnt_q;
    logic [RBW-1:0]    tcnt_q;
    logic [SW-1:0]     scnt_q;
    logic [IW-1:0]     icnt_q;
    logic [CHAL_W-1:0] bin_q;
    logic [CHAL_W-1:0] chal_q;
    logic [RESP_W-1:0] resp_q;
    logic              puf_en_q;
    logic              tx_valid_q;
    logic              done_q;
    logic              rx_ready_q;

    logic              acc;
    logic [CHAL_W+7:0] wide;
    logic [CHAL_W-1:0] nb;
    logic [RESP_W-1:0] cap;

    assign acc  = (state_q == S_RX) && rx_ready_q && bus.rx_valid;
    assign wide = {bin_q, bus.rx_data};
    assign nb   = wide[CHAL_W-1:0];
`ifdef PUF_LOOPBACK_EN
    assign cap  = bus.check ? RESP_W'(bin_q) : bus.response;
`else
    assign cap  = bus.response;
`endif

    assign bus.rx_ready  = rx_ready_q;
    assign bus.challenge = chal_q;
    assign bus.puf_en    = puf_en_q;
    assign bus.tx_data   = resp_q[RESP_W-1 -: 8];
    assign bus.tx_valid  = tx_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != S_RX) || (rcnt_q != '0);

    // Sequencer FSM: collect challenge bytes, hold puf_en for the settle window, then stream the response out
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RX;
            rcnt_q     <= '0;
            tcnt_q     <= '0;
            scnt_q     <= '0;
            icnt_q     <= '0;
            bin_q      <= '0;
            chal_q     <= '0;
            resp_q     <= '0;
            puf_en_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            rx_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RX: begin
                    if (acc) begin
                        icnt_q <= '0;
                        bin_q  <= nb;
                        if (rcnt_q == CBW'(CB - 1)) begin
                            rcnt_q     <= '0;
                            chal_q     <= nb ^ (nb >> 1);
                            puf_en_q   <= 1'b1;
                            rx_ready_q <= 1'b0;
                            scnt_q     <= '0;
                            state_q    <= S_EVAL;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end else if (RX_TIMEOUT > 0 && rcnt_q != '0) begin
                        if (icnt_q == IW'(RX_TIMEOUT - 1)) begin
                            rcnt_q <= '0;
                            bin_q  <= '0;
                            icnt_q <= '0;
                        end else begin
                            icnt_q <= icnt_q + 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    if (scnt_q == SW'(SETTLE_CYC - 1)) begin
                        resp_q     <= cap;
                        puf_en_q   <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tcnt_q     <= '0;
                        state_q    <= S_TX;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                S_TX: begin
                    if (bus.tx_ready) begin
                        resp_q <= resp_q << 8;
                        if (tcnt_q == RBW'(RB - 1)) begin
                            tcnt_q     <= '0;
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            rx_ready_q <= 1'b1;
                            state_q    <= S_RX;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_RX;
            endcase
        end
    end
endmodule
